// File: rtl/tcdm_rsp_reorder.sv
// Purpose : Reorder buffer between the TCDM ID remapper and the banked interconnect.
//           Issue order of req_ids is kept in an order FIFO; out-of-order responses
//           land in a slot array indexed by req_id and leave strictly in issue order.
// Latency : request path is combinational; response release takes 1 cycle minimum.
// Backpr. : requests stall while RobDepth are outstanding; a held response keeps
//           its payload stable until the remapper accepts it.
// Ports   : clk_i/rst_ni clock and async active-low reset; slv_req_i/slv_rsp_o to the
//           remapper; mst_req_o/mst_rsp_i to the interconnect; outstanding_o = number
//           of requests not yet returned upstream; id_error_o = sticky bad-response flag.

package tcdm_rsp_reorder_pkg;
  localparam int unsigned TcdmIdWidth   = 2;
  localparam int unsigned TcdmAddrWidth = 32;
  localparam int unsigned TcdmDataWidth = 32;

  typedef struct packed {
    logic [TcdmIdWidth-1:0] req_id;
  } user_t;

  typedef struct packed {
    logic [TcdmAddrWidth-1:0]   addr;
    logic                       write;
    logic [TcdmDataWidth-1:0]   data;
    logic [TcdmDataWidth/8-1:0] strb;
    user_t                      user;
  } req_chan_t;

  typedef struct packed {
    logic [TcdmDataWidth-1:0] data;
    user_t                    user;
  } rsp_chan_t;

  typedef struct packed {
    req_chan_t q;
    logic      q_valid;
    logic      p_ready;
  } dreq_t;

  typedef struct packed {
    rsp_chan_t p;
    logic      p_valid;
    logic      q_ready;
  } drsp_t;
endpackage

module tcdm_rsp_reorder #(
  parameter int unsigned RobDepth      = 4,
  parameter int unsigned IdWidth       = 2,
  parameter type         user_t        = tcdm_rsp_reorder_pkg::user_t,
  parameter type         rsp_chan_t    = tcdm_rsp_reorder_pkg::rsp_chan_t,
  parameter type         dreq_t        = tcdm_rsp_reorder_pkg::dreq_t,
  parameter type         drsp_t        = tcdm_rsp_reorder_pkg::drsp_t,
  // Checks for a response hitting an occupied slot; a bench that injects that
  // fault on purpose clears this so the sticky error flag can be observed.
  parameter bit          ChkSlotReuse  = 1'b1,
  localparam int unsigned PtrW         = $clog2(RobDepth),
  localparam int unsigned CntW         = PtrW + 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  dreq_t           slv_req_i,
  output drsp_t           slv_rsp_o,
  output dreq_t           mst_req_o,
  input  drsp_t           mst_rsp_i,
  output logic [CntW-1:0] outstanding_o,
  output logic            id_error_o
);

  logic [IdWidth-1:0]  r_fifo [RobDepth];
  logic [PtrW-1:0]     r_wptr, r_rptr;
  logic [CntW-1:0]     r_count;
  rsp_chan_t           r_slot [RobDepth];
  logic [RobDepth-1:0] r_slot_vld;
  logic                r_id_err;
  logic                r_hold;

  logic               w_full, w_empty, w_push, w_pop, w_push_dup;
  logic [IdWidth-1:0] w_push_id, w_head_id, w_cap_id;
  logic [PtrW-1:0]    w_head_idx, w_cap_idx;
  logic               w_head_ok, w_cap_vld, w_cap_in_range, w_cap_occ, w_cap_ok;
  logic               w_rsp_vld;
  user_t              w_cap_user;

  // Full is taken from the registered count, so a push never relies on a same-cycle pop.
  assign w_full    = (r_count == CntW'(RobDepth));
  assign w_empty   = (r_count == '0);
  assign w_push_id = slv_req_i.q.user.req_id;
  assign w_push    = slv_req_i.q_valid && mst_rsp_i.q_ready && !w_full;

  assign w_head_id  = r_fifo[r_rptr];
  assign w_head_idx = w_head_id[PtrW-1:0];
  assign w_head_ok  = (32'(w_head_id) < RobDepth);
  assign w_rsp_vld  = !w_empty && w_head_ok && r_slot_vld[w_head_idx];
  assign w_pop      = w_rsp_vld && slv_req_i.p_ready;

  assign w_cap_user     = mst_rsp_i.p.user;
  assign w_cap_id       = w_cap_user.req_id;
  assign w_cap_idx      = w_cap_id[PtrW-1:0];
  assign w_cap_vld      = mst_rsp_i.p_valid;
  assign w_cap_in_range = (32'(w_cap_id) < RobDepth);
  assign w_cap_occ      = w_cap_in_range && r_slot_vld[w_cap_idx];
  // A colliding or out-of-range response is dropped; the slot keeps its first data.
  assign w_cap_ok       = w_cap_vld && w_cap_in_range && !r_slot_vld[w_cap_idx];

  always_comb begin
    mst_req_o         = slv_req_i;
    mst_req_o.q_valid = slv_req_i.q_valid && !w_full;
    mst_req_o.p_ready = 1'b1;
    slv_rsp_o         = '0;
    slv_rsp_o.p       = r_slot[w_head_idx];
    slv_rsp_o.p_valid = w_rsp_vld;
    slv_rsp_o.q_ready = mst_rsp_i.q_ready && !w_full;
  end

  assign outstanding_o = r_count;
  assign id_error_o    = r_id_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_slot_vld <= '0;
      r_id_err   <= 1'b0;
      r_hold     <= 1'b0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CntW'(1);
        2'b01:   r_count <= r_count - CntW'(1);
        default: r_count <= r_count;
      endcase
      // Capture and release never target the same slot without a collision,
      // so the clear and the set below are independent.
      if (w_pop)    r_slot_vld[w_head_idx] <= 1'b0;
      if (w_cap_ok) r_slot_vld[w_cap_idx]  <= 1'b1;
      if (w_cap_vld && !w_cap_ok) r_id_err <= 1'b1;
      r_hold <= w_rsp_vld && !slv_req_i.p_ready;
    end
  end

  // Payload storage needs no reset: validity lives in r_slot_vld and r_count.
  always_ff @(posedge clk_i) begin
    if (w_push)   r_fifo[r_wptr]    <= w_push_id;
    if (w_cap_ok) r_slot[w_cap_idx] <= mst_rsp_i.p;
  end

  // Is the pushed id already waiting in the order FIFO?
  always_comb begin
    w_push_dup = 1'b0;
    for (int i = 0; i < RobDepth; i++) begin
      if ((CntW'(i) < r_count) && (r_fifo[r_rptr + PtrW'(i)] == w_push_id)) begin
        w_push_dup = 1'b1;
      end
    end
  end

  a_slot_reuse: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(ChkSlotReuse && w_cap_vld && w_cap_occ));
  a_vld_drop: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(r_hold && !w_rsp_vld));
  a_dup_push: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(w_push && w_push_dup));

endmodule

// File: tb/tb_tcdm_rsp_reorder.sv
// Purpose : directed bench for tcdm_rsp_reorder (in-order, reorder, stall,
//           backpressure, id error, async reset).
// Timing  : inputs change 1 time unit after a rising edge; outputs are sampled
//           mid-cycle, well clear of either clock edge.

module tb_tcdm_rsp_reorder;
  import tcdm_rsp_reorder_pkg::*;

  logic       clk_i = 1'b0;
  logic       rst_ni;
  dreq_t      slv_req, mst_req;
  drsp_t      slv_rsp, mst_rsp;
  logic [2:0] outstanding;
  logic       id_err;

  int total = 0;
  int pass  = 0;

  always #5 clk_i = ~clk_i;

  tcdm_rsp_reorder #(.ChkSlotReuse(1'b0)) dut (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .slv_req_i    (slv_req),
    .slv_rsp_o    (slv_rsp),
    .mst_req_o    (mst_req),
    .mst_rsp_i    (mst_rsp),
    .outstanding_o(outstanding),
    .id_error_o   (id_err)
  );

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    slv_req           = '0;
    slv_req.p_ready   = 1'b1;
    mst_rsp           = '0;
    mst_rsp.q_ready   = 1'b1;
  endtask

  task automatic do_reset();
    idle();
    rst_ni = 1'b0;
    tick();
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic drive_req(input logic [1:0] id);
    slv_req.q.addr        = 32'h1000 + 32'(id) * 4;
    slv_req.q.write       = 1'b0;
    slv_req.q.user.req_id = id;
    slv_req.q_valid       = 1'b1;
  endtask

  task automatic drive_rsp(input logic [1:0] id, input logic [31:0] data);
    mst_rsp.p.data        = data;
    mst_rsp.p.user.req_id = id;
    mst_rsp.p_valid       = 1'b1;
  endtask

  task automatic test_reset();
    idle();
    rst_ni = 1'b0;
    #3;
    total++; if (slv_rsp.p_valid !== 1'b0) $display("FAIL rst_pvalid got=%h exp=0", slv_rsp.p_valid); else pass++;
    total++; if (outstanding !== 3'd0) $display("FAIL rst_outstanding got=%0d exp=0", outstanding); else pass++;
    total++; if (id_err !== 1'b0) $display("FAIL rst_id_err got=%h exp=0", id_err); else pass++;
    total++; if (mst_req.p_ready !== 1'b1) $display("FAIL rst_mst_p_ready got=%h exp=1", mst_req.p_ready); else pass++;
    total++; if (slv_rsp.q_ready !== 1'b1) $display("FAIL rst_q_ready got=%h exp=1", slv_rsp.q_ready); else pass++;
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_in_order();
    do_reset();
    drive_req(2'd0);
    #2;
    total++; if (mst_req.q_valid !== 1'b1) $display("FAIL io_q_valid got=%h exp=1", mst_req.q_valid); else pass++;
    total++; if (mst_req.q.addr !== 32'h1000) $display("FAIL io_q_addr got=%h exp=00001000", mst_req.q.addr); else pass++;
    tick();
    slv_req.q_valid = 1'b0;
    drive_rsp(2'd0, 32'hA5A5_0000);
    #2;
    total++; if (slv_rsp.p_valid !== 1'b0) $display("FAIL io_no_bypass got=%h exp=0", slv_rsp.p_valid); else pass++;
    total++; if (outstanding !== 3'd1) $display("FAIL io_outst1 got=%0d exp=1", outstanding); else pass++;
    tick();
    mst_rsp.p_valid = 1'b0;
    #2;
    total++; if (slv_rsp.p_valid !== 1'b1) $display("FAIL io_pvalid got=%h exp=1", slv_rsp.p_valid); else pass++;
    total++; if (slv_rsp.p.data !== 32'hA5A5_0000) $display("FAIL io_data got=%h exp=a5a50000", slv_rsp.p.data); else pass++;
    tick();
    #2;
    total++; if (slv_rsp.p_valid !== 1'b0) $display("FAIL io_pvalid_off got=%h exp=0", slv_rsp.p_valid); else pass++;
    total++; if (outstanding !== 3'd0) $display("FAIL io_outst0 got=%0d exp=0", outstanding); else pass++;
  endtask

  task automatic test_reorder();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_req(2'(i));
      tick();
    end
    slv_req.q_valid = 1'b0;
    #2;
    total++; if (outstanding !== 3'd4) $display("FAIL ro_outst4 got=%0d exp=4", outstanding); else pass++;
    for (int i = 3; i >= 0; i--) begin
      drive_rsp(2'(i), 32'h100 + 32'(i));
      #2;
      total++; if (slv_rsp.p_valid !== 1'b0) $display("FAIL ro_wait%0d got=%h exp=0", i, slv_rsp.p_valid); else pass++;
      tick();
    end
    mst_rsp.p_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      total++; if (slv_rsp.p_valid !== 1'b1) $display("FAIL ro_pvalid%0d got=%h exp=1", i, slv_rsp.p_valid); else pass++;
      total++; if (slv_rsp.p.data !== 32'h100 + 32'(i)) $display("FAIL ro_data%0d got=%h exp=%h", i, slv_rsp.p.data, 32'h100 + 32'(i)); else pass++;
      tick();
    end
    #2;
    total++; if (slv_rsp.p_valid !== 1'b0) $display("FAIL ro_done_pvalid got=%h exp=0", slv_rsp.p_valid); else pass++;
    total++; if (outstanding !== 3'd0) $display("FAIL ro_outst0 got=%0d exp=0", outstanding); else pass++;
  endtask

  task automatic test_full_stall();
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive_req(2'(i));
      tick();
    end
    drive_req(2'd0);
    drive_rsp(2'd0, 32'h400);
    #2;
    total++; if (mst_req.q_valid !== 1'b0) $display("FAIL st_q_valid got=%h exp=0", mst_req.q_valid); else pass++;
    total++; if (slv_rsp.q_ready !== 1'b0) $display("FAIL st_q_ready got=%h exp=0", slv_rsp.q_ready); else pass++;
    tick();
    mst_rsp.p_valid = 1'b0;
    #2;
    total++; if (slv_rsp.p_valid !== 1'b1) $display("FAIL st_pvalid got=%h exp=1", slv_rsp.p_valid); else pass++;
    total++; if (mst_req.q_valid !== 1'b0) $display("FAIL st_q_valid_pop got=%h exp=0", mst_req.q_valid); else pass++;
    tick();
    #2;
    total++; if (outstanding !== 3'd3) $display("FAIL st_outst3 got=%0d exp=3", outstanding); else pass++;
    total++; if (mst_req.q_valid !== 1'b1) $display("FAIL st_q_valid_go got=%h exp=1", mst_req.q_valid); else pass++;
    total++; if (slv_rsp.q_ready !== 1'b1) $display("FAIL st_q_ready_go got=%h exp=1", slv_rsp.q_ready); else pass++;
    tick();
    slv_req.q_valid = 1'b0;
    #2;
    total++; if (outstanding !== 3'd4) $display("FAIL st_outst4 got=%0d exp=4", outstanding); else pass++;
  endtask

  task automatic test_backpressure();
    do_reset();
    drive_req(2'd0);
    tick();
    drive_req(2'd1);
    tick();
    slv_req.q_valid = 1'b0;
    slv_req.p_ready = 1'b0;
    drive_rsp(2'd0, 32'h200);
    tick();
    drive_rsp(2'd1, 32'h201);
    for (int k = 0; k < 5; k++) begin
      #2;
      total++; if (slv_rsp.p_valid !== 1'b1) $display("FAIL bp_hold%0d got=%h exp=1", k, slv_rsp.p_valid); else pass++;
      total++; if (slv_rsp.p.data !== 32'h200) $display("FAIL bp_data%0d got=%h exp=00000200", k, slv_rsp.p.data); else pass++;
      tick();
      if (k == 0) mst_rsp.p_valid = 1'b0;
    end
    total++; if (outstanding !== 3'd2) $display("FAIL bp_outst2 got=%0d exp=2", outstanding); else pass++;
    slv_req.p_ready = 1'b1;
    #2;
    total++; if (slv_rsp.p.data !== 32'h200) $display("FAIL bp_rel0 got=%h exp=00000200", slv_rsp.p.data); else pass++;
    tick();
    #2;
    total++; if (slv_rsp.p_valid !== 1'b1) $display("FAIL bp_pvalid1 got=%h exp=1", slv_rsp.p_valid); else pass++;
    total++; if (slv_rsp.p.data !== 32'h201) $display("FAIL bp_rel1 got=%h exp=00000201", slv_rsp.p.data); else pass++;
    tick();
    #2;
    total++; if (outstanding !== 3'd0) $display("FAIL bp_outst0 got=%0d exp=0", outstanding); else pass++;
  endtask

  task automatic test_id_error();
    do_reset();
    drive_req(2'd2);
    tick();
    slv_req.q_valid = 1'b0;
    slv_req.p_ready = 1'b0;
    drive_rsp(2'd2, 32'h300);
    tick();
    drive_rsp(2'd2, 32'h3FF);
    #2;
    total++; if (id_err !== 1'b0) $display("FAIL er_first got=%h exp=0", id_err); else pass++;
    tick();
    mst_rsp.p_valid = 1'b0;
    #2;
    total++; if (id_err !== 1'b1) $display("FAIL er_set got=%h exp=1", id_err); else pass++;
    total++; if (slv_rsp.p.data !== 32'h300) $display("FAIL er_keep got=%h exp=00000300", slv_rsp.p.data); else pass++;
    repeat (3) tick();
    slv_req.p_ready = 1'b1;
    tick();
    #2;
    total++; if (id_err !== 1'b1) $display("FAIL er_sticky got=%h exp=1", id_err); else pass++;
    total++; if (outstanding !== 3'd0) $display("FAIL er_outst0 got=%0d exp=0", outstanding); else pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_req(2'(i));
      tick();
    end
    slv_req.q_valid = 1'b0;
    slv_req.p_ready = 1'b0;
    drive_rsp(2'd0, 32'h500);
    tick();
    mst_rsp.p_valid = 1'b0;
    #2;
    total++; if (slv_rsp.p_valid !== 1'b1) $display("FAIL ar_pre_pvalid got=%h exp=1", slv_rsp.p_valid); else pass++;
    total++; if (outstanding !== 3'd3) $display("FAIL ar_pre_outst got=%0d exp=3", outstanding); else pass++;
    rst_ni = 1'b0;
    #1;
    total++; if (slv_rsp.p_valid !== 1'b0) $display("FAIL ar_pvalid got=%h exp=0", slv_rsp.p_valid); else pass++;
    total++; if (outstanding !== 3'd0) $display("FAIL ar_outst got=%0d exp=0", outstanding); else pass++;
    tick();
    idle();
    rst_ni = 1'b1;
    tick();
    #2;
    total++; if (slv_rsp.p_valid !== 1'b0) $display("FAIL ar_post_pvalid got=%h exp=0", slv_rsp.p_valid); else pass++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_reorder();
    test_full_stall();
    test_backpressure();
    test_id_error();
    test_async_reset();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end

endmodule
